// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
// Shares the single LC-3 memory port between the CPU datapath and a
// DMA/display requester. Each access is sequenced over a fixed-latency
// synchronous memory. The owner's ready pulse (cpu_r = R, or dma_ack)
// fires MEM_LAT+1 cycles after its request is sampled in IDLE. Ties are
// broken by alternating against the last granted requester. All outputs
// come straight from registers.
module lc3_mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_mioen,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_r,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic       OWN_CPU = 1'b0;
    localparam logic       OWN_DMA = 1'b1;
    localparam logic [3:0] LAT_M1  = 4'(MEM_LAT - 1);
    localparam logic       LAT_ONE = (MEM_LAT == 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_r_q, cpu_r_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          grant_dma_s;
    logic          finish_s;

    // Arbitration choice: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        if (cpu_mioen && dma_req) begin
            grant_dma_s = (last_grant_q == OWN_CPU);
        end else if (dma_req) begin
            grant_dma_s = 1'b1;
        end else begin
            grant_dma_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_r_d      = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_ack_d    = 1'b0;
        dma_rdata_d  = dma_rdata_q;
        finish_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_mioen || dma_req) begin
                    // Latch the winning request; later input changes are ignored.
                    state_d      = ST_ACCESS;
                    owner_d      = grant_dma_s ? OWN_DMA : OWN_CPU;
                    last_grant_d = grant_dma_s ? OWN_DMA : OWN_CPU;
                    mem_en_d     = 1'b1;
                    mem_we_d     = grant_dma_s ? dma_we    : cpu_rw;
                    mem_addr_d   = grant_dma_s ? dma_addr  : cpu_addr;
                    mem_wdata_d  = grant_dma_s ? dma_wdata : cpu_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_d = LAT_M1;
                if (LAT_ONE) begin
                    // Single-cycle memory: data is valid during the strobe cycle.
                    state_d  = ST_DONE;
                    finish_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // "<= 1" also recovers from a corrupted zero count.
                if (cnt_q <= 4'd1) begin
                    state_d  = ST_DONE;
                    finish_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion: raise the owner's pulse and capture read data for reads only.
        if (finish_s) begin
            if (owner_q == OWN_DMA) begin
                dma_ack_d = 1'b1;
                if (!mem_we_q) begin
                    dma_rdata_d = mem_rdata;
                end else begin
                    dma_rdata_d = dma_rdata_q;
                end
            end else begin
                cpu_r_d = 1'b1;
                if (!mem_we_q) begin
                    cpu_rdata_d = mem_rdata;
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
            end
        end else begin
            cpu_r_d   = 1'b0;
            dma_ack_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= OWN_DMA;
            owner_q      <= OWN_CPU;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {AW{1'b0}};
            mem_wdata_q  <= {DW{1'b0}};
            cpu_r_q      <= 1'b0;
            cpu_rdata_q  <= {DW{1'b0}};
            dma_ack_q    <= 1'b0;
            dma_rdata_q  <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_r_q      <= cpu_r_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_ack_q    <= dma_ack_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_r     = cpu_r_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares the single LC-3 memory port between the CPU datapath and a DMA/display requester.
- Sequences each access over a fixed-latency synchronous memory.
- Returns the ready flag R that the microsequencer waits on during memory states.
- Sits between the controller/datapath (MIOEN, R.W, MAR, MDR) and the memory array.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_mioen  in  1  CPU memory request; held high until cpu_r
- cpu_rw  in  1  1 = write, 0 = read
- cpu_addr  in  AW  MAR value
- cpu_wdata  in  DW  MDR value for writes
- cpu_rdata  out  DW  read data; valid while cpu_r=1
- cpu_r  out  1  one-cycle ready pulse (R)
- dma_req  in  1  DMA request; held high until dma_ack
- dma_we  in  1  1 = write
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_rdata  out  DW  read data; valid while dma_ack=1
- dma_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, wait counter=0, last_grant=DMA (so the CPU wins the first tie).
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_r, cpu_rdata, dma_ack, dma_rdata.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Sample cpu_mioen and dma_req.
  - If one is high, grant it.
  - If both are high, grant the requester that is not last_grant; update last_grant.
  - On grant, register addr/wdata/we/owner and go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - mem_en=1; mem_we, mem_addr, mem_wdata driven from the registered request.
  - Load counter with MEM_LAT-1.
  - Next state is WAIT, or DONE if MEM_LAT=1.
- WAIT:
  - mem_en=0; mem_addr, mem_we and mem_wdata hold their values.
  - Decrement the counter. When it reaches 0, capture mem_rdata into the owner's rdata register and go to DONE.
  - The capture happens on the edge ending cycle t+MEM_LAT, where t is the request-sample cycle.
- DONE (1 cycle):
  - The owner's ready pulse (cpu_r or dma_ack) is 1; rdata is valid. Then go to IDLE.
  - For writes, rdata is unchanged from its previous value.
- Latency: request sampled in IDLE at cycle t -> mem_en at t+1 -> ready at t+MEM_LAT+1. Default MEM_LAT=2 gives ready at t+3.
- Minimum spacing:
  - A new request is accepted no earlier than the cycle after DONE.
  - A requester that keeps its request high through the DONE cycle starts a new access.
  - The microsequencer leaves its memory state on the edge ending the R cycle, so this never double-issues.
- Fairness: strict alternation when both requesters are continuously active; no starvation.
- Request withdrawn mid-access: the access completes, and the ready/ack pulse still fires.
- Requester input changes after grant are ignored; the values latched in IDLE are used.
- Reset mid-access: return to IDLE at once; no ready/ack pulse; mem_en=0 from the next cycle. A partially issued write is not retried.
- Only one of cpu_r/dma_ack is high in any cycle; mem_en is high for exactly one cycle per access.

Test Plan:
- CPU read after reset:
  - Stimulus: mem[x3000]=x1234; cpu_mioen=1, cpu_rw=0, cpu_addr=x3000 sampled at cycle 0.
  - Response: mem_en=1 at cycle 1 only; cpu_r=1 at cycle 3 with cpu_rdata=x1234; dma_ack stays 0.
- CPU write:
  - Stimulus: cpu_rw=1, addr=x4000, wdata=xBEEF.
  - Response: mem_we=1 and mem_en=1 at cycle 1 with mem_addr=x4000; cpu_r at cycle 3; a later read of x4000 returns xBEEF.
- Simultaneous requests, both held:
  - Stimulus: CPU read x0010 and DMA read x0020 from cycle 0.
  - Response: CPU is granted first (cpu_r at cycle 3); DMA is granted in the IDLE at cycle 4 (dma_ack at cycle 7); then CPU again (ready at cycle 11). Strict alternation.
- MEM_LAT=1 build:
  - Stimulus: CPU read sampled at cycle 0.
  - Response: cpu_r at cycle 2; the WAIT state is never entered.
- Reset mid-access:
  - Stimulus: DMA write issued; rst_n=0 at cycle 2, released at cycle 3.
  - Response: dma_ack never pulses; all outputs are 0 at cycle 3; a subsequent CPU read completes with normal latency.
- Withdrawn request:
  - Stimulus: CPU read granted; cpu_mioen dropped at cycle 1.
  - Response: cpu_r still pulses at cycle 3; no second mem_en.
